// File: rtl/inst_enc.sv
// inst_enc: packs opcode/funct3/register fields and an immediate into an RV32
// instruction word (I/S/B/U/J scatter) and expands a load-immediate macro into
// ADDI, LUI, or LUI+ADDI. Registered output, valid/ready on both sides.
// IMM_W has to match the core's immediate width.
module inst_enc #(
    parameter int unsigned IMM_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_li_i,
    input  logic [4:0]       req_sel_i,
    input  logic [6:0]       req_opcode_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [6:0]       req_funct7_i,
    input  logic [4:0]       req_rd_i,
    input  logic [4:0]       req_rs1_i,
    input  logic [4:0]       req_rs2_i,
    input  logic [IMM_W-1:0] req_imm_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_inst_o,
    output logic             out_last_o,
    output logic             out_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        EMIT2 = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        accept;
    logic        out_fire;
    logic        sel_onehot;
    logic [11:0] li_lo;
    logic [19:0] li_hi;
    logic [31:0] enc_inst;
    logic        enc_last;
    logic        enc_err;
    logic [31:0] enc_pend;
    logic [31:0] pend_inst_q;
    logic        pend_err_q;

    // funct7 only matters for R-type, which this encoder does not produce
    logic unused_funct7;
    assign unused_funct7 = ^req_funct7_i;

    // true when v equals the sign extension of its low n bits
    function automatic logic fits(input logic [IMM_W-1:0] v, input int unsigned n);
        logic [IMM_W-1:0] t;
        t = $signed(v) >>> (n - 1);
        return (t == '0) || (t == '1);
    endfunction

    assign accept   = req_valid_i & req_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    // Request encoder: builds the first word, its flags and any pending second LI word
    always_comb begin
        enc_inst   = '0;
        enc_last   = 1'b1;
        enc_err    = 1'b0;
        enc_pend   = '0;
        sel_onehot = (req_sel_i != 5'd0) && ((req_sel_i & (req_sel_i - 5'd1)) == 5'd0);
        li_lo      = req_imm_i[11:0];
        // (imm + 0x800)[31:12] rounds the upper part so the signed ADDI lo lands on imm
        li_hi      = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
        if (req_li_i) begin
            enc_err = ~fits(req_imm_i, 32);
            if (fits(req_imm_i, 12)) begin
                enc_inst = {li_lo, 5'd0, 3'b000, req_rd_i, 7'h13};
            end else if (li_lo == 12'd0) begin
                enc_inst = {li_hi, req_rd_i, 7'h37};
            end else begin
                enc_inst = {li_hi, req_rd_i, 7'h37};
                enc_last = 1'b0;
                enc_pend = {li_lo, req_rd_i, 3'b000, req_rd_i, 7'h13};
            end
        end else if (!sel_onehot) begin
            enc_inst = '0;
            enc_err  = 1'b1;
        end else begin
            unique case (req_sel_i)
                5'b00001: begin
                    enc_inst = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
                    enc_err  = ~fits(req_imm_i, 12);
                end
                5'b00010: begin
                    enc_inst = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                                req_imm_i[4:0], req_opcode_i};
                    enc_err  = ~fits(req_imm_i, 12);
                end
                5'b00100: begin
                    enc_inst = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                                req_imm_i[4:1], req_imm_i[11], req_opcode_i};
                    enc_err  = ~fits(req_imm_i, 13) | req_imm_i[0];
                end
                5'b01000: begin
                    enc_inst = {req_imm_i[31:12], req_rd_i, req_opcode_i};
                    enc_err  = (req_imm_i[11:0] != 12'd0) | ~fits(req_imm_i, 32);
                end
                5'b10000: begin
                    enc_inst = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                                req_rd_i, req_opcode_i};
                    enc_err  = ~fits(req_imm_i, 21) | req_imm_i[0];
                end
                default: begin
                    enc_inst = '0;
                    enc_err  = 1'b1;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = EMIT;
            end
            EMIT: begin
                if (out_fire) begin
                    if (!out_last_o) state_d = EMIT2;
                    else if (accept) state_d = EMIT;
                    else state_d = IDLE;
                end
            end
            EMIT2: begin
                if (out_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        out_valid_o = (state_q != IDLE);
        req_ready_o = (state_q == IDLE) | ((state_q == EMIT) & out_last_o & out_ready_i);
    end

    // Output word register: loads on accept, swaps in the pending ADDI after the LUI handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_inst_o  <= '0;
            out_last_o  <= 1'b0;
            out_err_o   <= 1'b0;
            pend_inst_q <= '0;
            pend_err_q  <= 1'b0;
        end else if (accept) begin
            out_inst_o  <= enc_inst;
            out_last_o  <= enc_last;
            out_err_o   <= enc_err;
            pend_inst_q <= enc_pend;
            pend_err_q  <= enc_err;
        end else if ((state_q == EMIT) && out_fire && !out_last_o) begin
            out_inst_o  <= pend_inst_q;
            out_last_o  <= 1'b1;
            out_err_o   <= pend_err_q;
        end
    end

endmodule

// File: tb/tb_inst_enc.sv
// tb_inst_enc: directed and random requests for inst_enc checked against a
// behavioural encoder model built from integer arithmetic.
module tb_inst_enc;

    typedef struct packed {
        logic [31:0] inst;
        logic        last;
        logic        err;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_li = 1'b0;
    logic [4:0]  req_sel = '0;
    logic [6:0]  req_opcode = '0;
    logic [2:0]  req_funct3 = '0;
    logic [6:0]  req_funct7 = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_last;
    logic        out_err;

    int unsigned npass = 0;
    int unsigned nfail = 0;
    int unsigned ntot  = 0;
    word_t       exp_q[$];

    inst_enc #(.IMM_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_li_i     (req_li),
        .req_sel_i    (req_sel),
        .req_opcode_i (req_opcode),
        .req_funct3_i (req_funct3),
        .req_funct7_i (req_funct7),
        .req_rd_i     (req_rd),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .req_imm_i    (req_imm),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_inst_o   (out_inst),
        .out_last_o   (out_last),
        .out_err_o    (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntot++;
        assert (obs === expv) begin
            npass++;
        end else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rtype_free(input logic [31:0] imm12, input logic [31:0] rs1,
                                               input logic [31:0] f3, input logic [31:0] rd,
                                               input logic [31:0] op);
        return (imm12 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + op;
    endfunction

    // Reference: expected words for one request, appended to exp_q
    function automatic void model(input logic li, input logic [4:0] sel, input logic [6:0] op7,
                                  input logic [2:0] f3_, input logic [4:0] rd_, input logic [4:0] rs1_,
                                  input logic [4:0] rs2_, input logic [31:0] imm);
        int          s;
        logic [31:0] op, f3, rd, rs1, rs2, lo, hi, w;
        logic        e;
        s   = int'(imm);
        op  = 32'(op7);
        f3  = 32'(f3_);
        rd  = 32'(rd_);
        rs1 = 32'(rs1_);
        rs2 = 32'(rs2_);
        if (li) begin
            lo = imm & 32'hFFF;
            hi = ((imm + 32'h800) >> 12) & 32'hFFFFF;
            if (s >= -2048 && s <= 2047) begin
                exp_q.push_back('{rtype_free(lo, 0, 0, rd, 32'h13), 1'b1, 1'b0});
            end else if (lo == 0) begin
                exp_q.push_back('{(hi << 12) + (rd << 7) + 32'h37, 1'b1, 1'b0});
            end else begin
                exp_q.push_back('{(hi << 12) + (rd << 7) + 32'h37, 1'b0, 1'b0});
                exp_q.push_back('{rtype_free(lo, rd, 0, rd, 32'h13), 1'b1, 1'b0});
            end
        end else if ($countones(sel) != 1) begin
            exp_q.push_back('{32'h0, 1'b1, 1'b1});
        end else begin
            w = 0;
            e = 1'b0;
            case (sel)
                5'b00001: begin
                    w = rtype_free(imm & 32'hFFF, rs1, f3, rd, op);
                    e = (s < -2048) || (s > 2047);
                end
                5'b00010: begin
                    w = (((imm >> 5) & 32'h7F) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
                        + ((imm & 32'h1F) << 7) + op;
                    e = (s < -2048) || (s > 2047);
                end
                5'b00100: begin
                    w = (((imm >> 12) & 1) << 31) + (((imm >> 5) & 32'h3F) << 25) + (rs2 << 20)
                        + (rs1 << 15) + (f3 << 12) + (((imm >> 1) & 32'hF) << 8)
                        + (((imm >> 11) & 1) << 7) + op;
                    e = (s < -4096) || (s > 4095) || (s % 2 != 0);
                end
                5'b01000: begin
                    w = (imm & 32'hFFFFF000) + (rd << 7) + op;
                    e = (imm & 32'hFFF) != 0;
                end
                default: begin
                    w = (((imm >> 20) & 1) << 31) + (((imm >> 1) & 32'h3FF) << 21)
                        + (((imm >> 11) & 1) << 20) + (((imm >> 12) & 32'hFF) << 12) + (rd << 7) + op;
                    e = (s < -(1 << 20)) || (s >= (1 << 20)) || (s % 2 != 0);
                end
            endcase
            exp_q.push_back('{w, 1'b1, e});
        end
    endfunction

    // One request from IDLE, each word stalled for `stall` cycles before being taken
    task automatic do_req(input string tag, input logic li, input logic [4:0] sel, input logic [6:0] op,
                          input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, input int unsigned stall);
        word_t w;
        exp_q.delete();
        model(li, sel, op, f3, rd, rs1, rs2, imm);
        req_li = li; req_sel = sel; req_opcode = op; req_funct3 = f3;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_funct7 = 7'($urandom);
        req_valid = 1'b1;
        out_ready = (stall == 0);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_imm = $urandom; req_rd = 5'($urandom); req_sel = 5'($urandom); req_li = 1'($urandom);
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk({tag, ".valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".inst"}, out_inst, w.inst);
            chk({tag, ".last"}, 32'(out_last), 32'(w.last));
            chk({tag, ".err"}, 32'(out_err), 32'(w.err));
            for (int i = 0; i < int'(stall); i++) begin
                out_ready = 1'b0;
                @(posedge clk); #1;
                chk({tag, ".hold"}, out_inst, w.inst);
                chk({tag, ".stall_rdy"}, 32'(req_ready), 32'd0);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        chk({tag, ".idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] imm;
        logic [4:0]  sel;
        word_t       w;

        #2;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.inst", out_inst, 32'd0);
        chk("rst.last", 32'(out_last), 32'd0);
        chk("rst.err", 32'(out_err), 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd1);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Directed formats and boundaries
        do_req("i_neg1", 0, 5'b00001, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 0);
        chk("i_neg1.const", 32'hFFF10093, 32'hFFF10093 & {32{1'b1}});
        do_req("b_8", 0, 5'b00100, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, 0);
        do_req("b_odd", 0, 5'b00100, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd7, 0);
        do_req("b_max", 0, 5'b00100, 7'h63, 3'd1, 5'd0, 5'd3, 5'd4, 32'd4094, 1);
        do_req("b_over", 0, 5'b00100, 7'h63, 3'd1, 5'd0, 5'd3, 5'd4, 32'd4096, 0);
        do_req("s_min", 0, 5'b00010, 7'h23, 3'd2, 5'd0, 5'd7, 5'd9, 32'hFFFFF800, 0);
        do_req("i_over", 0, 5'b00001, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'd2048, 0);
        do_req("u_bad", 0, 5'b01000, 7'h37, 3'd0, 5'd3, 5'd0, 5'd0, 32'h00001001, 0);
        do_req("u_ok", 0, 5'b01000, 7'h17, 3'd0, 5'd3, 5'd0, 5'd0, 32'hABCDE000, 0);
        do_req("j_neg", 0, 5'b10000, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFF00000, 0);
        do_req("j_over", 0, 5'b10000, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00100000, 0);
        do_req("sel_bad", 0, 5'b00011, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'd5, 0);
        do_req("sel_zero", 0, 5'b00000, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'd5, 0);
        do_req("li_two", 1, 5'b00011, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 0);
        do_req("li_small", 1, 5'b00000, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h00000123, 0);
        do_req("li_lui", 1, 5'b00001, 7'h00, 3'd0, 5'd6, 5'd0, 5'd0, 32'h12345000, 2);
        do_req("li_x0", 1, 5'b00001, 7'h00, 3'd0, 5'd0, 5'd0, 5'd0, 32'h80000801, 0);

        // Backpressure with a competing request held valid
        exp_q.delete();
        model(1, 5'b0, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        req_li = 1; req_rd = 5'd5; req_imm = 32'h12345FFF; req_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        req_li = 0; req_sel = 5'b00001; req_imm = 32'd1;
        w = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            chk("bp.inst", out_inst, w.inst);
            chk("bp.ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        chk("bp.inst_end", out_inst, w.inst);
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        w = exp_q.pop_front();
        chk("bp.addi", out_inst, w.inst);
        chk("bp.addi_last", 32'(out_last), 32'd1);
        @(posedge clk); #1;
        chk("bp.no_extra", 32'(out_valid), 32'd0);

        // Reset right after the LUI handshake
        exp_q.delete();
        model(1, 5'b0, 7'h0, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
        req_li = 1; req_rd = 5'd5; req_imm = 32'h12345FFF; req_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = exp_q.pop_front();
        chk("rmid.lui", out_inst, w.inst);
        chk("rmid.lui_last", 32'(out_last), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rmid.valid", 32'(out_valid), 32'd0);
        chk("rmid.inst", out_inst, 32'd0);
        chk("rmid.ready", 32'(req_ready), 32'd1);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rmid.quiet", 32'(out_valid), 32'd0);
        end

        // Back-to-back streaming of 8 I-type requests
        exp_q.delete();
        out_ready = 1'b1;
        req_li = 1'b0;
        req_sel = 5'b00001;
        for (int k = 0; k < 8; k++) begin
            req_opcode = 7'h13;
            req_funct3 = 3'(k);
            req_rd = 5'(k + 1);
            req_rs1 = 5'(31 - k);
            req_imm = 32'($signed(12'($urandom)));
            model(0, 5'b00001, 7'h13, 3'(k), 5'(k + 1), 5'(31 - k), 5'd0, req_imm);
            req_valid = 1'b1;
            chk("stream.ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
            w = exp_q.pop_front();
            chk("stream.inst", out_inst, w.inst);
            chk("stream.err", 32'(out_err), 32'(w.err));
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream.idle", 32'(out_valid), 32'd0);

        // Random requests across all formats, LI and bad selects
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: imm = 32'($signed(12'($urandom)));
                1: imm = 32'($signed(14'($urandom)));
                2: imm = $urandom;
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            sel = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(1 << $urandom_range(0, 4));
            do_req("rand", 1'($urandom_range(0, 3) == 0), sel, 7'($urandom), 3'($urandom),
                   5'($urandom), 5'($urandom), 5'($urandom), imm, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
